// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port ROM among NUM_REQ requesters.
// One read outstanding at most; a stalled response word is parked in a hold register.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          busy
);

    localparam int TW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [TW-1:0]         r_rr_ptr;
    logic [TW-1:0]         r_tag;
    logic [DATA_WIDTH-1:0] r_hold_q;

    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic [TW-1:0]         w_idx;
    logic [TW-1:0]         w_sel;
    logic [TW-1:0]         w_sel_inc;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_any_valid;
    logic                  w_tag_ready;
    logic                  w_done;
    logic                  w_can_issue;
    logic                  w_issue;
    logic                  w_load_hold;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign w_addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Scan from the farthest offset down to rr_ptr so the closest valid requester wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_idx       = '0;
        w_sel       = '0;
        w_any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = TW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any_valid = 1'b1;
                w_sel       = w_idx;
            end
        end
    end

    assign w_sel_addr  = w_addr_arr[w_sel];
    assign w_sel_inc   = (w_sel == TW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    assign w_tag_ready = rsp_ready[r_tag];
    assign w_done      = (r_state != ST_IDLE) && w_tag_ready;
    assign w_can_issue = (r_state == ST_IDLE) || w_done;
    // Gating with rst_n keeps grants and rom_addr quiet while reset is held.
    assign w_issue     = rst_n && w_can_issue && w_any_valid;

    assign req_ready = w_issue ? (ONE << w_sel) : '0;
    assign rom_addr  = w_issue ? w_sel_addr : '0;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = busy ? (ONE << r_tag) : '0;

    always_comb begin
        rsp_data = '0;
        case (r_state)
            ST_READ: rsp_data = rom_data;
            ST_HOLD: rsp_data = r_hold_q;
            default: rsp_data = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_load_hold  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) w_next_state = ST_READ;
            end
            ST_READ: begin
                if (w_tag_ready) begin
                    w_next_state = w_issue ? ST_READ : ST_IDLE;
                end else begin
                    // ROM output is only valid this cycle; park it before it is overwritten.
                    w_load_hold  = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tag_ready) w_next_state = w_issue ? ST_READ : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_tag    <= '0;
            // NOTE: the hold word is a single register, so it is reset like any other state.
            r_hold_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_tag    <= w_sel;
                r_rr_ptr <= w_sel_inc;
            end
            if (w_load_hold) r_hold_q <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed, table-driven bench for rom_read_arbiter with a 1-cycle registered ROM model
// (rom[a] = a[7:0] ^ 8'hA5); each vector drives one cycle and checks mid-cycle outputs.
module tb_rom_read_arbiter;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  valid;
        logic [39:0] addr;
        logic [3:0]  rdy;
        logic [3:0]  e_grant;
        logic [3:0]  e_rsp;
        logic [7:0]  e_data;
        logic        e_busy;
        logic [9:0]  e_rom;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [39:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [7:0]  rsp_data;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic        busy;

    int n_vectors = 0;
    int n_checks = 0;
    int n_miscompares = 0;

    vec_t tbl[$];

    rom_read_arbiter #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(8),
        .NUM_REQ   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic [3:0] v,
                                input logic [39:0] a, input logic [3:0] rdy,
                                input logic [3:0] g, input logic [3:0] rsp,
                                input logic [7:0] d, input logic b, input logic [9:0] ra);
        vec_t t;
        t.name = name; t.rst_n = r; t.valid = v; t.addr = a; t.rdy = rdy;
        t.e_grant = g; t.e_rsp = rsp; t.e_data = d; t.e_busy = b; t.e_rom = ra;
        return t;
    endfunction

    // Drive just after the rising edge, check just before the next one.
    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst_n     = t.rst_n;
        req_valid = t.valid;
        req_addr  = t.addr;
        rsp_ready = t.rdy;
        @(negedge clk);
        n_vectors++;
        check({t.name, ".req_ready"}, 32'(req_ready), 32'(t.e_grant));
        check({t.name, ".rsp_valid"}, 32'(rsp_valid), 32'(t.e_rsp));
        check({t.name, ".rsp_data"},  32'(rsp_data),  32'(t.e_data));
        check({t.name, ".busy"},      32'(busy),      32'(t.e_busy));
        check({t.name, ".rom_addr"},  32'(rom_addr),  32'(t.e_rom));
    endtask

    localparam logic [39:0] RR_A  = {10'h344, 10'h033, 10'h022, 10'h011};
    localparam logic [39:0] ONE_A = {10'h000, 10'h000, 10'h000, 10'h003};
    localparam logic [39:0] STL_A = {10'h000, 10'h033, 10'h010, 10'h000};
    localparam logic [39:0] RST_A = {10'h155, 10'h000, 10'h0AA, 10'h000};

    initial begin
        // reset, round robin, single read, stall with pending request
        tbl.push_back(mk("reset",  0, 4'hF, RR_A,  4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));
        tbl.push_back(mk("rr0",    1, 4'hF, RR_A,  4'hF, 4'b0001, 4'b0000, 8'h00, 0, 10'h011));
        tbl.push_back(mk("rr1",    1, 4'hF, RR_A,  4'hF, 4'b0010, 4'b0001, 8'hB4, 1, 10'h022));
        tbl.push_back(mk("rr2",    1, 4'hF, RR_A,  4'hF, 4'b0100, 4'b0010, 8'h87, 1, 10'h033));
        tbl.push_back(mk("rr3",    1, 4'hF, RR_A,  4'hF, 4'b1000, 4'b0100, 8'h96, 1, 10'h344));
        tbl.push_back(mk("rr4",    1, 4'hF, RR_A,  4'hF, 4'b0001, 4'b1000, 8'hE1, 1, 10'h011));
        tbl.push_back(mk("rr5",    1, 4'h0, RR_A,  4'hF, 4'b0000, 4'b0001, 8'hB4, 1, 10'h000));
        tbl.push_back(mk("one0",   1, 4'h1, ONE_A, 4'hF, 4'b0001, 4'b0000, 8'h00, 0, 10'h003));
        tbl.push_back(mk("one1",   1, 4'h0, ONE_A, 4'hF, 4'b0000, 4'b0001, 8'hA6, 1, 10'h000));
        tbl.push_back(mk("one2",   1, 4'h0, ONE_A, 4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));
        tbl.push_back(mk("stall0", 1, 4'h2, STL_A, 4'hD, 4'b0010, 4'b0000, 8'h00, 0, 10'h010));
        tbl.push_back(mk("stall1", 1, 4'h4, STL_A, 4'hD, 4'b0000, 4'b0010, 8'hB5, 1, 10'h000));
        tbl.push_back(mk("stall2", 1, 4'h4, STL_A, 4'hD, 4'b0000, 4'b0010, 8'hB5, 1, 10'h000));
        tbl.push_back(mk("stall3", 1, 4'h4, STL_A, 4'hD, 4'b0000, 4'b0010, 8'hB5, 1, 10'h000));
        tbl.push_back(mk("stall4", 1, 4'h4, STL_A, 4'h2, 4'b0100, 4'b0010, 8'hB5, 1, 10'h033));
        tbl.push_back(mk("stall5", 1, 4'h0, STL_A, 4'hF, 4'b0000, 4'b0100, 8'h96, 1, 10'h000));
        tbl.push_back(mk("stall6", 1, 4'h0, STL_A, 4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset while a read is outstanding: response drops at once, req3 then served.
        apply(mk("mid0", 1, 4'h2, RST_A, 4'hF, 4'b0010, 4'b0000, 8'h00, 0, 10'h0AA));
        apply(mk("mid1", 0, 4'h2, RST_A, 4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));
        apply(mk("mid2", 1, 4'h8, RST_A, 4'hF, 4'b1000, 4'b0000, 8'h00, 0, 10'h155));
        apply(mk("mid3", 1, 4'h0, RST_A, 4'hF, 4'b0000, 4'b1000, 8'hF0, 1, 10'h000));
        apply(mk("mid4", 1, 4'h0, RST_A, 4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));

        // Leave rr_ptr at 2, reset, then all-valid must grant requester 0.
        apply(mk("ptr0", 1, 4'h2, RST_A, 4'hF, 4'b0010, 4'b0000, 8'h00, 0, 10'h0AA));
        apply(mk("ptr1", 1, 4'h0, RST_A, 4'hF, 4'b0000, 4'b0010, 8'h0F, 1, 10'h000));
        apply(mk("ptr2", 0, 4'h0, RR_A,  4'hF, 4'b0000, 4'b0000, 8'h00, 0, 10'h000));
        apply(mk("ptr3", 1, 4'hF, RR_A,  4'hF, 4'b0001, 4'b0000, 8'h00, 0, 10'h011));
        apply(mk("ptr4", 1, 4'h0, RR_A,  4'hF, 4'b0000, 4'b0001, 8'hB4, 1, 10'h000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
